// File: rtl/mem_io_bridge.sv
// Load/store bridge: address-decoded IO window (synced inputs, latched outputs, debounced confirm) plus sized data-memory access.
// Memory path and read data are combinational; IO writes land at the next edge; no backpressure, every strobe is accepted.
module mem_io_bridge #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int          N_IN    = 4,
  parameter int          IN_W    = 16,
  parameter int          N_OUT   = 4,
  parameter int          OUT_W   = 24,
  parameter int          DB_CNT  = 500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            r_rdata,
  input  logic [31:0]            m_rdata,
  input  logic [N_IN*IN_W-1:0]   sw_in,
  input  logic                   btn_confirm,
  output logic [31:0]            addr_out,
  output logic [31:0]            m_wdata,
  output logic [3:0]             m_byte_en,
  output logic [31:0]            r_wdata,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic [N_OUT-1:0]       out_strobe,
  output logic                   confirm_pending,
  output logic                   misalign
);

  localparam int CNT_W = $clog2(DB_CNT);

  logic [N_IN*IN_W-1:0]   sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic                   btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic                   stable_q, stable_d, pending_q, pending_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_OUT*OUT_W-1:0] out_data_q, out_data_d;
  logic [N_OUT-1:0]       out_strobe_q, out_strobe_d;

  logic        io_hit, is_half, is_word, word_off;
  logic        in_sel, out_sel, status_sel, out_wr, status_clr, rise;
  logic [7:0]  offset;
  logic [3:0]  idx;
  logic [31:0] io_rdata, mem_ld, lane_sh;

  assign io_hit     = (addr_in[31:8] == IO_BASE[31:8]);
  assign offset     = addr_in[7:0];
  assign idx        = offset[5:2];
  assign word_off   = (offset[1:0] == 2'b00);
  assign is_half    = (funct3[1:0] == 2'b01);
  assign is_word    = (funct3[1:0] == 2'b10);
  assign status_sel = (offset == 8'h40);
  assign in_sel     = (offset[7:6] == 2'b00) && word_off && (int'(idx) < N_IN);
  assign out_sel    = (offset[7:6] == 2'b10) && word_off && (int'(idx) < N_OUT);
  assign out_wr     = mem_write && io_hit && out_sel;
  assign status_clr = mem_read && io_hit && status_sel;

  assign misalign = (mem_read | mem_write) & ~io_hit &
                    ((is_half & addr_in[0]) | (is_word & (|addr_in[1:0])));
  assign addr_out = {addr_in[31:2], 2'b00};

  always_comb begin
    io_rdata = '0;
    if (status_sel) begin
      io_rdata = {31'b0, pending_q};
    end else if (in_sel) begin
      for (int k = 0; k < N_IN; k++)
        if (idx == 4'(k)) io_rdata[IN_W-1:0] = sw_sync_q[k*IN_W +: IN_W];
    end else if (out_sel) begin
      for (int k = 0; k < N_OUT; k++)
        if (idx == 4'(k)) io_rdata[OUT_W-1:0] = out_data_q[k*OUT_W +: OUT_W];
    end
  end

  // Shift the addressed lane down to bit 0, then extend by access type.
  assign lane_sh = m_rdata >> {addr_in[1:0], 3'b000};

  always_comb begin
    mem_ld = '0;
    case (funct3)
      3'b000:  mem_ld = {{24{lane_sh[7]}}, lane_sh[7:0]};
      3'b100:  mem_ld = {24'b0, lane_sh[7:0]};
      3'b001:  mem_ld = {{16{lane_sh[15]}}, lane_sh[15:0]};
      3'b101:  mem_ld = {16'b0, lane_sh[15:0]};
      3'b010:  mem_ld = m_rdata;
      default: mem_ld = '0;
    endcase
  end

  always_comb begin
    r_wdata = '0;
    if (mem_read) begin
      if (io_hit)         r_wdata = io_rdata;
      else if (!misalign) r_wdata = mem_ld;
    end
  end

  always_comb begin
    m_wdata = r_rdata;
    case (funct3[1:0])
      2'b00:   m_wdata = {4{r_rdata[7:0]}};
      2'b01:   m_wdata = {2{r_rdata[15:0]}};
      default: m_wdata = r_rdata;
    endcase
  end

  always_comb begin
    m_byte_en = 4'b0000;
    if (mem_write && !io_hit && !misalign) begin
      case (funct3[1:0])
        2'b00:   m_byte_en = 4'b0001 << addr_in[1:0];
        2'b01:   m_byte_en = addr_in[1] ? 4'b1100 : 4'b0011;
        2'b10:   m_byte_en = 4'b1111;
        default: m_byte_en = 4'b0000;
      endcase
    end
  end

  always_comb begin
    sw_meta_d  = sw_in;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = btn_confirm;
    btn_sync_d = btn_meta_q;

    stable_d = stable_q;
    cnt_d    = '0;
    if (btn_sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DB_CNT - 1)) stable_d = ~stable_q;
      else                             cnt_d    = cnt_q + CNT_W'(1);
    end
    rise = stable_d & ~stable_q;
    // A new press outranks a same-cycle status read.
    pending_d = rise | (pending_q & ~status_clr);

    out_data_d   = out_data_q;
    out_strobe_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (out_wr && idx == 4'(k)) begin
        out_data_d[k*OUT_W +: OUT_W] = r_rdata[OUT_W-1:0];
        out_strobe_d[k]              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      stable_q     <= 1'b0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_strobe_q <= '0;
    end else begin
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      stable_q     <= stable_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_strobe      = out_strobe_q;
  assign confirm_pending = pending_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge with DB_CNT=8: directed vectors, literal checks and a per-cycle reference model.
module tb_mem_io_bridge;
  localparam int DB = 8;

  logic        clk, rst_n, mem_read, mem_write, btn_confirm;
  logic [2:0]  funct3;
  logic [31:0] addr_in, r_rdata, m_rdata;
  logic [63:0] sw_in;
  logic [31:0] addr_out, m_wdata, r_wdata;
  logic [3:0]  m_byte_en, out_strobe;
  logic [95:0] out_data;
  logic        confirm_pending, misalign;

  int total = 0;
  int bad   = 0;

  mem_io_bridge #(.DB_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr_in(addr_in), .r_rdata(r_rdata), .m_rdata(m_rdata),
    .sw_in(sw_in), .btn_confirm(btn_confirm), .addr_out(addr_out),
    .m_wdata(m_wdata), .m_byte_en(m_byte_en), .r_wdata(r_wdata),
    .out_data(out_data), .out_strobe(out_strobe),
    .confirm_pending(confirm_pending), .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [63:0] sw_h0 = '0, sw_h1 = '0;
  logic        b_h0 = 1'b0, b_h1 = 1'b0, stab = 1'b0, pend = 1'b0;
  int          run = 0;
  logic [23:0] out_m [4];
  logic [3:0]  strb_m = '0;

  function automatic logic io_at(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFC;
  endfunction

  function automatic logic is_out_off(input logic [7:0] off);
    return off >= 8'h80 && off < 8'h90 && off[1:0] == 2'b00;
  endfunction

  function automatic logic exp_mis();
    if (!(mem_read || mem_write) || io_at(addr_in)) return 1'b0;
    if (funct3[1:0] == 2'b01) return addr_in % 2 != 0;
    if (funct3[1:0] == 2'b10) return addr_in % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (funct3[1:0] == 2'b00) return 32'(r_rdata[7:0]) * 32'h0101_0101;
    if (funct3[1:0] == 2'b01) return 32'(r_rdata[15:0]) * 32'h0001_0001;
    return r_rdata;
  endfunction

  function automatic logic [3:0] exp_be();
    int sh;
    sh = int'(addr_in[1:0]);
    if (!mem_write || io_at(addr_in) || exp_mis()) return 4'd0;
    case (funct3[1:0])
      2'b00:   return 4'(1 << sh);
      2'b01:   return 4'(3 << sh);
      2'b10:   return 4'hF;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [7:0]  off;
    logic [31:0] sh;
    off = addr_in[7:0];
    if (!mem_read) return 32'd0;
    if (io_at(addr_in)) begin
      if (off == 8'h40) return {31'b0, pend};
      if (off < 8'h10 && off[1:0] == 2'b00) return {16'b0, sw_h1[off[5:2]*16 +: 16]};
      if (is_out_off(off)) return {8'b0, out_m[off[5:2]]};
      return 32'd0;
    end
    if (exp_mis()) return 32'd0;
    sh = m_rdata >> (8 * addr_in[1:0]);
    case (funct3)
      3'b000:  return 32'(sh[7:0])  - (sh[7]  ? 32'h100   : 32'd0);
      3'b100:  return 32'(sh[7:0]);
      3'b001:  return 32'(sh[15:0]) - (sh[15] ? 32'h10000 : 32'd0);
      3'b101:  return 32'(sh[15:0]);
      3'b010:  return m_rdata;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model update at each edge; reset clears it immediately.
  initial begin
    logic       rise;
    logic [7:0] off;
    for (int k = 0; k < 4; k++) out_m[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sw_h0 = '0; sw_h1 = '0; b_h0 = 0; b_h1 = 0; stab = 0; pend = 0; run = 0;
        strb_m = '0;
        for (int k = 0; k < 4; k++) out_m[k] = '0;
      end else begin
        off  = addr_in[7:0];
        rise = 1'b0;
        if (b_h1 != stab) begin
          run++;
          if (run == DB) begin
            stab = ~stab;
            run  = 0;
            rise = stab;
          end
        end else begin
          run = 0;
        end
        if (rise) pend = 1'b1;
        else if (mem_read && io_at(addr_in) && off == 8'h40) pend = 1'b0;
        strb_m = '0;
        if (mem_write && io_at(addr_in) && is_out_off(off)) begin
          out_m[off[5:2]]  = r_rdata[23:0];
          strb_m[off[5:2]] = 1'b1;
        end
        b_h1 = b_h0; b_h0 = btn_confirm;
        sw_h1 = sw_h0; sw_h0 = sw_in;
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("addr_out", addr_out, addr_in & 32'hFFFF_FFFC);
        chk("m_wdata", m_wdata, exp_wdata());
        chk("m_byte_en", {28'b0, m_byte_en}, {28'b0, exp_be()});
        chk("misalign", {31'b0, misalign}, {31'b0, exp_mis()});
        chk("r_wdata", r_wdata, exp_rd());
        chk("out_strobe", {28'b0, out_strobe}, {28'b0, strb_m});
        chk("pending", {31'b0, confirm_pending}, {31'b0, pend});
        for (int k = 0; k < 4; k++)
          chk("out_data", {8'b0, out_data[k*24 +: 24]}, {8'b0, out_m[k]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read = 0; mem_write = 0; funct3 = 3'b010; addr_in = 32'h0000_1000;
    r_rdata = 0;
  endtask

  initial begin
    rst_n = 0; btn_confirm = 0; sw_in = '0; m_rdata = 0;
    idle();
    repeat (3) tick();
    chk("rst out_data", out_data[31:0], 32'd0);
    chk("rst out_strobe", {28'b0, out_strobe}, 32'd0);
    chk("rst pending", {31'b0, confirm_pending}, 32'd0);
    chk("rst r_wdata", r_wdata, 32'd0);
    rst_n = 1;
    tick();

    // Output channel write, strobe and read-back.
    mem_write = 1; addr_in = 32'hFFFF_FC80; r_rdata = 32'h0000_ABCD;
    #1 chk("io write be", {28'b0, m_byte_en}, 32'd0);
    tick();
    chk("ch0 data", {8'b0, out_data[23:0]}, 32'h0000_ABCD);
    chk("ch0 strobe", {28'b0, out_strobe}, 32'h1);
    idle();
    tick();
    chk("ch0 strobe end", {28'b0, out_strobe}, 32'h0);
    mem_read = 1; addr_in = 32'hFFFF_FC80;
    #1 chk("ch0 readback", r_wdata, 32'h0000_ABCD);
    tick();

    // Back-to-back writes to channel 1.
    idle(); mem_write = 1; addr_in = 32'hFFFF_FC84; r_rdata = 32'h1111_1111;
    tick();
    r_rdata = 32'h2222_2222;
    chk("b2b strobe1", {28'b0, out_strobe}, 32'h2);
    chk("b2b data1", {8'b0, out_data[47:24]}, 32'h0011_1111);
    tick();
    idle();
    chk("b2b strobe2", {28'b0, out_strobe}, 32'h2);
    chk("b2b data2", {8'b0, out_data[47:24]}, 32'h0022_2222);
    tick();
    chk("b2b strobe end", {28'b0, out_strobe}, 32'h0);

    // Input channel sync latency and invalid offsets.
    sw_in[47:32] = 16'h1234;
    mem_read = 1; addr_in = 32'hFFFF_FC08;
    tick();
    chk("sw not yet", r_wdata, 32'd0);
    tick();
    chk("sw ch2", r_wdata, 32'h0000_1234);
    addr_in = 32'hFFFF_FC10;
    #1 chk("bad in off", r_wdata, 32'd0);
    tick();
    idle(); mem_write = 1; addr_in = 32'hFFFF_FC30; r_rdata = 32'h00FF_FFFF;
    tick();
    idle();
    chk("bad out off strobe", {28'b0, out_strobe}, 32'h0);

    // Memory loads and stores.
    m_rdata = 32'h80FF_7F01; mem_read = 1;
    funct3 = 3'b000; addr_in = 32'h0000_1003;
    #1 chk("LB +3", r_wdata, 32'hFFFF_FF80);
    tick(); funct3 = 3'b100;
    #1 chk("LBU +3", r_wdata, 32'h0000_0080);
    tick(); funct3 = 3'b001; addr_in = 32'h0000_1002;
    #1 chk("LH +2", r_wdata, 32'hFFFF_80FF);
    tick(); funct3 = 3'b101; addr_in = 32'h0000_1000;
    #1 chk("LHU +0", r_wdata, 32'h0000_7F01);
    tick(); idle(); mem_write = 1; funct3 = 3'b000; addr_in = 32'h0000_1001; r_rdata = 32'h0000_005A;
    #1 chk("SB wdata", m_wdata, 32'h5A5A_5A5A);
    chk("SB be", {28'b0, m_byte_en}, 32'b0010);
    tick(); funct3 = 3'b001; addr_in = 32'h0000_1002; r_rdata = 32'h0000_BEEF;
    #1 chk("SH wdata", m_wdata, 32'hBEEF_BEEF);
    chk("SH be", {28'b0, m_byte_en}, 32'b1100);
    tick(); idle(); mem_read = 1; funct3 = 3'b010; addr_in = 32'h0000_1002;
    #1 chk("LW mis", {31'b0, misalign}, 32'd1);
    chk("LW mis data", r_wdata, 32'd0);
    tick(); idle(); mem_write = 1; funct3 = 3'b001; addr_in = 32'h0000_1001;
    #1 chk("SH mis", {31'b0, misalign}, 32'd1);
    chk("SH mis be", {28'b0, m_byte_en}, 32'd0);
    tick(); idle();

    // Short glitch is rejected.
    btn_confirm = 1;
    repeat (5) tick();
    btn_confirm = 0;
    repeat (20) tick();
    chk("glitch pending", {31'b0, confirm_pending}, 32'd0);

    // Held press: pending rises on the tenth edge.
    btn_confirm = 1;
    repeat (9) tick();
    chk("press edge9", {31'b0, confirm_pending}, 32'd0);
    tick();
    chk("press edge10", {31'b0, confirm_pending}, 32'd1);
    repeat (10) tick();
    btn_confirm = 0;
    repeat (15) tick();
    mem_read = 1; addr_in = 32'hFFFF_FC40;
    #1 chk("status read1", r_wdata, 32'd1);
    tick();
    chk("status read2", r_wdata, 32'd0);
    chk("status cleared", {31'b0, confirm_pending}, 32'd0);
    idle();
    tick();

    // Debounced edge coincident with status read.
    btn_confirm = 1;
    repeat (9) tick();
    mem_read = 1; addr_in = 32'hFFFF_FC40;
    #1 chk("coinc read", r_wdata, 32'd0);
    tick();
    idle();
    chk("coinc pending", {31'b0, confirm_pending}, 32'd1);

    // Reset in the middle of a release debounce.
    btn_confirm = 0;
    repeat (4) tick();
    chk("mid cnt", 32'(dut.cnt_q), 32'd2);
    chk("mid stable", {31'b0, dut.stable_q}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("arst cnt", 32'(dut.cnt_q), 32'd0);
    chk("arst stable", {31'b0, dut.stable_q}, 32'd0);
    chk("arst pending", {31'b0, confirm_pending}, 32'd0);
    chk("arst out_data", out_data[31:0], 32'd0);
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Parametrised memory/IO bridge between the CPU load/store path, data memory and board peripherals. Addresses in the IO window go to N_IN synchronised input channels, N_OUT latched output channels and a debounced confirm-button status register; all other addresses go to data memory. The bridge also handles byte, half and word access with sign or zero extension. It replaces register-selected IO with address-decoded, clocked IO.

## Interface
- DATA_W, 32, bus width (fixed 32 for RV32)
- IO_BASE, 32'hFFFF_FC00, IO window base; hit when addr_in[31:8] == IO_BASE[31:8]
- N_IN, 4, input channels (1..16)
- IN_W, 16, input channel width (≤32)
- N_OUT, 4, output channels (1..16)
- OUT_W, 24, output channel width (≤32)
- DB_CNT, 500000, debounce stable-cycle count (≥2)

Ports:
- clk  in  1  system clock; one clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  load strobe from controller
- mem_write  in  1  store strobe from controller
- funct3  in  3  access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU)
- addr_in  in  32  ALU result address
- r_rdata  in  32  store data from register file
- m_rdata  in  32  word read from data memory
- sw_in  in  N_IN*IN_W  raw switch inputs; channel k is bits [k*IN_W +: IN_W]
- btn_confirm  in  1  raw confirm button, active-high
- addr_out  out  32  word address to data memory ({addr_in[31:2],2'b00})
- m_wdata  out  32  lane-replicated store data
- m_byte_en  out  4  byte write mask to data memory
- r_wdata  out  32  load result to register file
- out_data  out  N_OUT*OUT_W  latched output channels (LED, seven-segment, ...)
- out_strobe  out  N_OUT  one-cycle pulse per channel write
- confirm_pending  out  1  sticky confirm flag
- misalign  out  1  misaligned access flag

## Operation
- Register map (offset = addr_in[7:0]):
  - 0x00+4k, k<N_IN: input channel k, read-only, zero-extended
  - 0x40: status; bit0 = confirm_pending; reading clears it
  - 0x80+4k, k<N_OUT: output channel k, write-only with read-back
  - any other offset: reads return 0, writes are ignored
- IO accesses use the whole word. funct3 is ignored for IO; writes take r_rdata[OUT_W-1:0].
- Memory load: select the byte or half lane by addr_in[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Memory store:
  - SB: replicate the byte into all 4 lanes; m_byte_en = 1<<addr[1:0]
  - SH: replicate the half into both halves; m_byte_en = 0011 or 1100
  - SW: m_byte_en = 1111
- m_byte_en is 0 when mem_write=0, on an IO hit, or when misaligned.
- misalign = (mem_read|mem_write) & !io_hit & ((half & addr[0]) | (word & addr[1:0]!=0)). A misaligned access returns r_wdata=0 and suppresses the memory write.
- When mem_read=0, r_wdata = 0.
- Inputs: each sw_in bit passes through a 2-flop synchroniser. Reads return the synchronised value.
- Confirm path:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments while the synced level differs from the stable level, and resets to 0 when they match.
  - At DB_CNT-1 the stable level toggles and the counter resets.
  - A rising edge of the stable level sets confirm_pending.
- Simultaneous set and read-clear in the same cycle: set wins; pending stays 1. The read itself returns the pre-edge value.

## Timing
- Reset (async assert, synchronous deassert use): out_data=0, out_strobe=0, confirm_pending=0, synchronisers=0, stable=0, counter=0.
- Combinational outputs (addr_out, m_wdata, m_byte_en, r_wdata, misalign) follow inputs with no latency.
- Output channel write: out_data updates at the rising edge where mem_write & io_hit & offset is valid. out_strobe[k] is high for exactly the following cycle.
- Back-to-back writes to the same channel: each write produces its own strobe, and the last value wins.
- Input latency: a sw_in change is visible to reads 2 clocks later.
- Confirm latency: press to pending = 2 (sync) + DB_CNT cycles. Glitches shorter than DB_CNT cycles are ignored. Release requires DB_CNT stable cycles before the next press can register.
- Status read-clear takes effect at the edge ending the read cycle.
- Reset asserted mid-debounce or mid-strobe clears all state immediately.

## Test plan
- Reset, then SW 0xABCD to 0x80 (N_OUT=4, OUT_W=24) -> out_data[23:0]=0x00ABCD the next cycle; out_strobe[0] is a one-cycle pulse; read 0x80 returns 0x0000ABCD.
- sw_in ch2=0x1234, wait 2 clocks, LW 0x08 -> r_wdata=0x00001234. Read at offset 0x10 (N_IN=4) -> 0; write to 0x30 -> no strobe.
- m_rdata=0x80FF7F01:
  - LB @+3 -> 0xFFFFFF80
  - LBU @+3 -> 0x00000080
  - LH @+2 -> 0xFFFF80FF
  - SB 0x5A @+1 -> m_wdata=0x5A5A5A5A, m_byte_en=0010
- LW @0x1002 -> misalign=1, r_wdata=0. SH @0x1001 -> misalign=1, m_byte_en=0000.
- With DB_CNT=8:
  - 5-cycle button pulse -> pending stays 0
  - 20-cycle press -> pending=1 at cycle 10
  - LW 0x40 -> returns 1, then reads 0
- Debounced rising edge coincident with a status read -> pending remains 1. Reset asserted mid-debounce -> counter, stable and pending are 0 immediately.
